// File: rtl/seg_scan_mux.sv
// Time-multiplexes DIGITS pre-decoded 7-segment patterns onto one shared bus with dead time and a
// double-buffered load/ready handshake. Optional macro SEG_SCAN_BRIGHT_EN adds bright[2:0] duty trim.
module seg_scan_mux #(
  parameter int         DIGITS  = 2,
  parameter int         DWELL   = 50000,
  parameter int         DEAD    = 16,
  parameter logic [6:0] SEG_OFF = 7'h7F
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
`ifdef SEG_SCAN_BRIGHT_EN
  input  logic [2:0]            bright,
`endif
  input  logic [7*DIGITS-1:0]   d_in,
  input  logic                  d_load,
  output logic                  d_ready,
  output logic [6:0]            seg_out,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_tick
);

  // state   | meaning
  // S_IDLE  | en low, bus blanked, index and counter held at 0
  // S_DEAD  | blanking gap of DEAD clocks before each digit
  // S_DRIVE | active[idx] on the bus with its one-hot select for DWELL clocks

  localparam int CNT_MAX = (DWELL > DEAD) ? DWELL : DEAD;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] DEAD_TC  = CW'(DEAD - 1);
  localparam logic [CW-1:0] DWELL_TC = CW'(DWELL - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_DEAD, S_DRIVE} state_t;

  state_t                state, state_nx;
  logic [CW-1:0]         cnt, cnt_nx;
  logic [IW-1:0]         idx, idx_nx;
  logic [6:0]            seg_nx;
  logic [DIGITS-1:0]     sel_nx;
  logic                  tick_nx;
  logic                  lit;

  logic [7*DIGITS-1:0]   act_buf, act_nx, pend_buf, pend_nx;
  logic                  pend_full, pend_full_nx;
  logic                  accept, boundary;

`ifdef SEG_SCAN_BRIGHT_EN
  localparam int OW = CW + 1;
  logic [OW-1:0]         on_len, on_len_nx;
`endif

  assign d_ready = ~pend_full;
  assign accept  = d_load & ~pend_full;

  // Leaving IDLE counts as a frame boundary so data loaded while idle shows on the first frame.
  // The regular boundary is the frame_tick cycle, which is always a blanked DEAD cycle.
  assign boundary = frame_tick | ((state == S_IDLE) & en);

  always_comb begin
    act_nx       = act_buf;
    pend_nx      = pend_buf;
    pend_full_nx = pend_full;
    if (boundary && pend_full) begin
      act_nx       = pend_buf;
      pend_full_nx = 1'b0;
    end else if (boundary && accept) begin
      act_nx = d_in;
    end else if (accept) begin
      pend_nx      = d_in;
      pend_full_nx = 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    tick_nx  = 1'b0;
    seg_nx   = SEG_OFF;
    sel_nx   = '0;
    lit      = 1'b1;
`ifdef SEG_SCAN_BRIGHT_EN
    on_len_nx = on_len;
`endif
    if (!en) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
      idx_nx   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_nx = S_DEAD;
          cnt_nx   = '0;
          idx_nx   = '0;
        end
        S_DEAD: begin
          if (cnt == DEAD_TC) begin
            state_nx = S_DRIVE;
            cnt_nx   = '0;
`ifdef SEG_SCAN_BRIGHT_EN
            on_len_nx = OW'(((int'(bright) + 1) * DWELL) / 8);
`endif
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        S_DRIVE: begin
          if (cnt == DWELL_TC) begin
            state_nx = S_DEAD;
            cnt_nx   = '0;
            if (idx == LAST_IDX) begin
              idx_nx  = '0;
              tick_nx = 1'b1;
            end else begin
              idx_nx = idx + 1'b1;
            end
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
          idx_nx   = '0;
        end
      endcase
    end

`ifdef SEG_SCAN_BRIGHT_EN
    lit = ({1'b0, cnt_nx} < on_len_nx);
`endif

    // Read from act_nx so a transfer on the edge entering DRIVE (DEAD=1) is already visible.
    if (state_nx == S_DRIVE) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (idx_nx == IW'(k)) begin
          seg_nx    = act_nx[7*k +: 7];
          sel_nx[k] = lit;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      seg_out    <= SEG_OFF;
      dig_sel    <= '0;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      idx        <= idx_nx;
      seg_out    <= seg_nx;
      dig_sel    <= sel_nx;
      frame_tick <= tick_nx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_buf   <= {DIGITS{SEG_OFF}};
      pend_buf  <= {DIGITS{SEG_OFF}};
      pend_full <= 1'b0;
    end else begin
      act_buf   <= act_nx;
      pend_buf  <= pend_nx;
      pend_full <= pend_full_nx;
    end
  end

`ifdef SEG_SCAN_BRIGHT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) on_len <= '0;
    else          on_len <= on_len_nx;
  end
`endif

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with DIGITS=2, DWELL=4, DEAD=2 (12-clock frame).
// With SEG_SCAN_BRIGHT_EN defined it also exercises the bright duty trim.
module tb_seg_scan_mux;
  localparam int         DIGITS = 2;
  localparam int         DWELL  = 4;
  localparam int         DEAD   = 2;
  localparam logic [6:0] OFF    = 7'h7F;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic        d_load = 1'b0;
  logic [13:0] d_in = '0;
  logic        d_ready;
  logic [6:0]  seg_out;
  logic [1:0]  dig_sel;
  logic        frame_tick;
`ifdef SEG_SCAN_BRIGHT_EN
  logic [2:0]  bright = 3'd7;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  localparam logic [13:0] DATA_X = {7'h0F, 7'h40};
  localparam logic [13:0] DATA_A = {7'h11, 7'h22};
  localparam logic [13:0] DATA_B = {7'h55, 7'h66};
  localparam logic [13:0] DATA_C = {7'h12, 7'h34};
  localparam logic [13:0] DATA_Z = {7'h3F, 7'h3F};

  seg_scan_mux #(.DIGITS(DIGITS), .DWELL(DWELL), .DEAD(DEAD), .SEG_OFF(OFF)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .en(en),
`ifdef SEG_SCAN_BRIGHT_EN
    .bright(bright),
`endif
    .d_in(d_in),
    .d_load(d_load),
    .d_ready(d_ready),
    .seg_out(seg_out),
    .dig_sel(dig_sel),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic apply_reset();
    en = 1'b0;
    d_load = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic load_now(input logic [13:0] data);
    d_in = data;
    d_load = 1'b1;
    tick();
    d_load = 1'b0;
  endtask

  // cyc=0 is the first cycle after the edge that samples en high
  task automatic start_en();
    en = 1'b1;
    tick();
    cyc = 0;
  endtask

  // Steady-state {frame_tick, dig_sel, seg_out} for cycle j after en rises, 12-clock frames
  function automatic logic [9:0] exp_frame(input int j, input logic [13:0] data);
    int p;
    logic t;
    p = j % 12;
    t = (j >= 12) && (p == 0);
    if (p >= 2 && p <= 5)       return {t, 2'b01, data[6:0]};
    else if (p >= 8 && p <= 11) return {t, 2'b10, data[13:7]};
    else                        return {t, 2'b00, OFF};
  endfunction

  task automatic test_reset();
    apply_reset();
    checks++; if (seg_out !== OFF) begin errors++; $display("FAIL reset_seg got %h want %h", seg_out, OFF); end
    checks++; if (dig_sel !== 2'b00) begin errors++; $display("FAIL reset_sel got %b want 00", dig_sel); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", frame_tick); end
    checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", d_ready); end
  endtask

  task automatic test_frames();
    logic [9:0] exp;
    apply_reset();
    load_now(DATA_X);
    checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL frames_ready_drop got %b want 0", d_ready); end
    start_en();
    checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL frames_ready_back got %b want 1", d_ready); end
    for (int j = 0; j < 26; j++) begin
      run_to(j);
      exp = exp_frame(j, DATA_X);
      checks++;
      if ({frame_tick, dig_sel, seg_out} !== exp) begin
        errors++;
        $display("FAIL frames_cyc%0d got tick=%b sel=%b seg=%h want tick=%b sel=%b seg=%h",
                 j, frame_tick, dig_sel, seg_out, exp[9], exp[8:7], exp[6:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    load_now(DATA_X);
    start_en();
    run_to(3);
    d_in = DATA_A;
    d_load = 1'b1;
    tick();
    checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_drop got %b want 0", d_ready); end
    d_in = DATA_B;
    run_to(7);
    d_load = 1'b0;
    run_to(9);
    checks++; if (seg_out !== DATA_X[13:7]) begin errors++; $display("FAIL bp_no_tear got %h want %h", seg_out, DATA_X[13:7]); end
    run_to(12);
    checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL bp_tick got %b want 1", frame_tick); end
    checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_at_tick got %b want 0", d_ready); end
    run_to(13);
    checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %b want 1", d_ready); end
    run_to(14);
    checks++; if ({dig_sel, seg_out} !== {2'b01, DATA_A[6:0]}) begin errors++; $display("FAIL bp_d0 got sel=%b seg=%h want sel=01 seg=%h", dig_sel, seg_out, DATA_A[6:0]); end
    run_to(20);
    checks++; if ({dig_sel, seg_out} !== {2'b10, DATA_A[13:7]}) begin errors++; $display("FAIL bp_d1 got sel=%b seg=%h want sel=10 seg=%h", dig_sel, seg_out, DATA_A[13:7]); end
  endtask

  task automatic test_coincident();
    apply_reset();
    load_now(DATA_X);
    start_en();
    run_to(12);
    checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL coin_tick got %b want 1", frame_tick); end
    d_in = DATA_Z;
    d_load = 1'b1;
    tick();
    d_load = 1'b0;
    for (int j = 13; j < 24; j++) begin
      run_to(j);
      checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL coin_ready_cyc%0d got %b want 1", j, d_ready); end
      if (j == 14) begin
        checks++; if ({dig_sel, seg_out} !== {2'b01, 7'h3F}) begin errors++; $display("FAIL coin_d0 got sel=%b seg=%h want sel=01 seg=3f", dig_sel, seg_out); end
      end
      if (j == 20) begin
        checks++; if ({dig_sel, seg_out} !== {2'b10, 7'h3F}) begin errors++; $display("FAIL coin_d1 got sel=%b seg=%h want sel=10 seg=3f", dig_sel, seg_out); end
      end
    end
  endtask

  task automatic test_en_drop();
    apply_reset();
    load_now(DATA_X);
    start_en();
    run_to(5);
    load_now(DATA_C);
    checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL drop_ready_pend got %b want 0", d_ready); end
    run_to(10);
    checks++; if ({dig_sel, seg_out} !== {2'b10, DATA_X[13:7]}) begin errors++; $display("FAIL drop_pre got sel=%b seg=%h want sel=10 seg=%h", dig_sel, seg_out, DATA_X[13:7]); end
    en = 1'b0;
    tick();
    checks++; if ({frame_tick, dig_sel, seg_out} !== {1'b0, 2'b00, OFF}) begin errors++; $display("FAIL drop_blank got tick=%b sel=%b seg=%h want tick=0 sel=00 seg=7f", frame_tick, dig_sel, seg_out); end
    for (int j = 0; j < 4; j++) begin
      tick();
      checks++; if ({frame_tick, dig_sel, d_ready} !== 4'b0000) begin errors++; $display("FAIL drop_idle%0d got tick=%b sel=%b ready=%b want 0 00 0", j, frame_tick, dig_sel, d_ready); end
    end
    start_en();
    checks++; if ({dig_sel, d_ready} !== 3'b001) begin errors++; $display("FAIL drop_restart0 got sel=%b ready=%b want 00 1", dig_sel, d_ready); end
    run_to(1);
    checks++; if (dig_sel !== 2'b00) begin errors++; $display("FAIL drop_restart1 got sel=%b want 00", dig_sel); end
    run_to(2);
    checks++; if ({dig_sel, seg_out} !== {2'b01, DATA_C[6:0]}) begin errors++; $display("FAIL drop_restart2 got sel=%b seg=%h want sel=01 seg=%h", dig_sel, seg_out, DATA_C[6:0]); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    load_now(DATA_X);
    start_en();
    run_to(3);
    checks++; if ({dig_sel, seg_out} !== {2'b01, DATA_X[6:0]}) begin errors++; $display("FAIL arst_pre got sel=%b seg=%h want sel=01 seg=%h", dig_sel, seg_out, DATA_X[6:0]); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if ({frame_tick, dig_sel, seg_out, d_ready} !== {1'b0, 2'b00, OFF, 1'b1}) begin errors++; $display("FAIL arst_now got tick=%b sel=%b seg=%h ready=%b want 0 00 7f 1", frame_tick, dig_sel, seg_out, d_ready); end
    en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    start_en();
    run_to(2);
    checks++; if ({dig_sel, seg_out} !== {2'b01, OFF}) begin errors++; $display("FAIL arst_active_cleared got sel=%b seg=%h want sel=01 seg=7f", dig_sel, seg_out); end
  endtask

`ifdef SEG_SCAN_BRIGHT_EN
  task automatic test_bright();
    logic [1:0] exp_sel;
    apply_reset();
    bright = 3'd3;
    load_now(DATA_X);
    start_en();
    for (int j = 2; j < 6; j++) begin
      run_to(j);
      exp_sel = (j < 4) ? 2'b01 : 2'b00;
      checks++; if ({dig_sel, seg_out} !== {exp_sel, DATA_X[6:0]}) begin errors++; $display("FAIL bright3_cyc%0d got sel=%b seg=%h want sel=%b seg=%h", j, dig_sel, seg_out, exp_sel, DATA_X[6:0]); end
    end
    apply_reset();
    bright = 3'd7;
    load_now(DATA_X);
    start_en();
    for (int j = 2; j < 6; j++) begin
      run_to(j);
      checks++; if ({dig_sel, seg_out} !== {2'b01, DATA_X[6:0]}) begin errors++; $display("FAIL bright7_cyc%0d got sel=%b seg=%h want sel=01 seg=%h", j, dig_sel, seg_out, DATA_X[6:0]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_frames();
    test_backpressure();
    test_coincident();
    test_en_drop();
    test_async_reset();
`ifdef SEG_SCAN_BRIGHT_EN
    test_bright();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Downstream of the binary-to-decimal seven-segment decoder.
- Takes DIGITS pre-decoded 7-bit segment patterns and time-multiplexes them onto one shared segment bus with one-hot digit selects.
- Inserts dead time between digits to prevent ghosting.
- Accepts new patterns through a load/ready handshake, double-buffered so that a displayed frame never tears.

Parameters:
- DIGITS, 2, number of multiplexed digits (2..8).
- DWELL, 50000, clocks each digit is driven per visit (>=2).
- DEAD, 16, clocks of blanking before each digit (>=1).
- SEG_OFF, 7'h7F, segment bus value meaning "all segments off" (segments are active-low).

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- en, input, 1, scan enable; low forces blanking.
- d_in, input, 7*DIGITS, segment patterns. Digit k occupies bits [7k+6:7k]; bit 7k+0 is segment a through bit 7k+6 segment g.
- d_load, input, 1, request to capture d_in.
- d_ready, output, 1, capture slot free; a load is accepted when d_load and d_ready are both high.
- seg_out, output, 7, shared segment bus (bit 0 = a).
- dig_sel, output, DIGITS, one-hot active-high digit enable; all-zero when blanked.
- frame_tick, output, 1, one-clock pulse at the end of each full scan frame.

Behaviour:
- Reset (async assert, sync release): outputs and registers take these values.
  - seg_out=SEG_OFF, dig_sel=0, frame_tick=0, d_ready=1.
  - Active and pending buffers all SEG_OFF; digit index=0; state=IDLE; counter=0.
- Buffers:
  - Pending register is loaded on an accepted load; d_ready drops the next cycle.
  - At each frame boundary, if pending is full it is copied to active and d_ready returns high the next cycle.
  - Only the active buffer is ever displayed.
- State machine (all outputs registered):
  - IDLE: outputs blanked. Go to DEAD with index=0 when en=1.
  - DEAD: seg_out=SEG_OFF, dig_sel=0, counts DEAD clocks, then goes to DRIVE.
  - DRIVE: seg_out=active[index], dig_sel=1<<index, counts DWELL clocks. At the end:
    - If index=DIGITS-1: index wraps to 0, frame_tick pulses for one clock, pending-to-active transfer happens.
    - Otherwise index increments.
    - Either way, go to DEAD.
- Timing:
  - Frame length is exactly DIGITS*(DEAD+DWELL) clocks.
  - Digit 0 is first driven DEAD+1 clocks after en rises. The +1 is the IDLE-to-DEAD transition cycle.
- Counter width is clog2(max(DWELL,DEAD)). Counter resets to 0 on every state entry.
- Boundary conditions:
  - en deasserted mid-operation: immediately blank outputs next cycle and go to IDLE. Index and counter clear. Pending is kept. No frame_tick is generated.
  - Load accepted in the same cycle as a frame boundary: the transfer uses the old pending contents if pending was full. If pending was empty, the new data goes straight to active and d_ready stays high.
  - d_load while d_ready=0 is ignored; no data is lost from pending.
  - reset_n asserted mid-frame: all state is returned to reset values asynchronously.

Optional Feature:
- Macro: SEG_SCAN_BRIGHT_EN.
- Enabled:
  - Adds input bright[2:0].
  - Within DRIVE, dig_sel is high only for the first ((bright+1)*DWELL)/8 clocks, then zero for the rest of DWELL. seg_out holds its pattern for the whole of DRIVE.
  - bright is sampled on entry to DRIVE.
  - bright=7 behaves identically to the disabled build.
- Disabled: no bright port; dig_sel is high for the whole of DRIVE.

Test Plan:
1. Reset and load, DIGITS=2, DWELL=4, DEAD=2.
   - Release reset, en=1, load d_in=14'h0F_40.
   - seg_out=7'h40 with dig_sel=2'b01 for 4 clocks, then 2 blank clocks.
   - Then seg_out=7'h0F with dig_sel=2'b10 for 4 clocks.
   - frame_tick pulses once every 12 clocks.
2. Handshake backpressure.
   - Load A mid-frame: d_ready drops.
   - Load B before the boundary: B is ignored.
   - After frame_tick, A is displayed and d_ready=1.
3. Boundary-coincident load with pending empty.
   - d_load on the frame_tick cycle with d_in=14'h3F_3F.
   - The next frame shows 7'h3F on both digits; d_ready is never deasserted.
4. en drop at DRIVE digit 1, count 2.
   - The next cycle shows dig_sel=0 and seg_out=7'h7F.
   - Re-raise en: digit 0 is driven DEAD+1 clocks later.
5. Async reset mid-DRIVE.
   - Assert reset_n=0 between clock edges: outputs go to reset values before the next edge.
   - Active buffer is cleared to SEG_OFF.
6. SEG_SCAN_BRIGHT_EN build, DWELL=8.
   - bright=3: dig_sel is high 4 of 8 DRIVE clocks.
   - bright=7: dig_sel is high 8 of 8.
